// File: rtl/noise_burst_sound.sv
// Noise-burst generator for crash, bang and explosion effects.
// The source is a 17-bit LFSR. Its amplitude comes either straight from the
// crsh nibble or from a triggered, linearly decaying envelope. A one-pole
// low-pass filter shapes the result, which is then registered onto out.
// Every register except pend advances only on the 48 kHz sample enable.
module noise_burst_sound #(
  parameter int OUT_W      = 16,
  parameter int AMP_W      = 4,
  parameter int NOISE_DIV  = 4,
  parameter int DECAY_DIV  = 256,
  parameter int FILT_SHIFT = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clk_en_48KHz,
  input  logic                    mode,
  input  logic                    trig,
  input  logic [AMP_W-1:0]        crsh,
  output logic signed [OUT_W-1:0] out
);

  localparam int NDIV_W = (NOISE_DIV > 1) ? $clog2(NOISE_DIV) : 1;
  localparam int DCNT_W = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
  localparam int SH     = OUT_W - 1 - AMP_W;
  localparam logic [NDIV_W-1:0] NDIV_LAST = NDIV_W'(NOISE_DIV - 1);
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DECAY_DIV - 1);

  logic [16:0]             lfsr;
  logic [NDIV_W-1:0]       ndiv;
  logic [AMP_W-1:0]        env;
  logic [DCNT_W-1:0]       dcnt;
  logic                    pend;
  logic signed [OUT_W-1:0] y;

  // A trigger seen on the enable cycle itself is consumed there, without waiting.
  logic take;
  assign take = pend | trig;

  // Step the LFSR. The all-zero lock-up state reloads the seed.
  logic [16:0] lfsr_step;
  assign lfsr_step = (lfsr == 17'd0) ? 17'h00001 : {lfsr[15:0], lfsr[16] ^ lfsr[13]};

  // The sample is built from pre-update state: the noise bit picks the sign of the
  // scaled amplitude. The largest magnitude, (2^AMP_W-1)<<SH, always fits in OUT_W.
  logic [AMP_W-1:0]        amp;
  logic [OUT_W-1:0]        mag;
  logic signed [OUT_W-1:0] x;
  assign amp = mode ? env : crsh;
  assign mag = OUT_W'(amp) << SH;
  assign x   = lfsr[16] ? $signed(mag) : -$signed(mag);

  // One-pole low-pass. The difference needs one extra bit. The update is a
  // fraction of the distance from y to x, so y never leaves the range of x.
  logic signed [OUT_W:0]   diff;
  logic signed [OUT_W-1:0] step;
  logic signed [OUT_W-1:0] y_nxt;
  assign diff  = $signed({x[OUT_W-1], x}) - $signed({y[OUT_W-1], y});
  assign step  = OUT_W'(diff >>> FILT_SHIFT);
  assign y_nxt = y + step;

  // Per-sample state update. Only the trigger latch runs on every clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= 17'h00001;
      ndiv <= '0;
      env  <= '0;
      dcnt <= '0;
      pend <= 1'b0;
      y    <= '0;
      out  <= '0;
    end else if (clk_en_48KHz) begin
      pend <= 1'b0;
      if (ndiv == NDIV_LAST) begin
        ndiv <= '0;
        lfsr <= lfsr_step;
      end else begin
        ndiv <= ndiv + 1'b1;
      end
      if (take) begin
        env  <= crsh;
        dcnt <= '0;
      end else if (env != '0) begin
        if (dcnt == DCNT_LAST) begin
          env  <= env - 1'b1;
          dcnt <= '0;
        end else begin
          dcnt <= dcnt + 1'b1;
        end
      end
      y   <= y_nxt;
      out <= y_nxt;
    end else if (trig) begin
      pend <= 1'b1;
    end
  end

endmodule

// File: doc/noise_burst_sound.md
Name: noise_burst_sound

Overview:
- Parametrised noise-burst generator for crash, bang and explosion effects.
- Produces band-limited noise whose amplitude comes either directly from a control nibble (direct mode) or from a triggered, linearly decaying envelope (envelope mode).
- Runs in the system clock domain, gated by the shared 48 kHz sample enable.
- Its signed output feeds the sound mixer.

Parameters:
- OUT_W, 16, output sample width (signed two's complement).
- AMP_W, 4, width of the amplitude/crash control input.
- NOISE_DIV, 4, number of sample enables per LFSR step (>=1).
- DECAY_DIV, 256, number of sample enables per envelope decrement (>=1).
- FILT_SHIFT, 3, one-pole low-pass coefficient 2^-FILT_SHIFT (0 = filter bypass).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- clk_en_48KHz  in  1  sample-rate enable, one clk wide.
- mode  in  1  0 = direct amplitude, 1 = envelope.
- trig  in  1  envelope trigger, level-sampled every clk.
- crsh  in  AMP_W  amplitude (mode 0) or envelope start level (mode 1).
- out  out  OUT_W  signed filtered noise sample.

Behaviour:
- Reset (rst=1 at a clk edge) sets: lfsr=17'h00001, ndiv=0, env=0, dcnt=0, pend=0, y=0, out=0. Reset wins over every other event, including mid-burst and coincident clk_en_48KHz.
- On cycles with clk_en_48KHz=0, only pend may change. All other state holds.
- pend is set on any clk with trig=1. It is cleared on the enable cycle that consumes it. If trig=1 and the enable coincide, that enable consumes the trigger.
- On each enable, all registers update simultaneously. Sample x is computed from pre-update register values.
- Noise:
  - n = lfsr[16].
  - When ndiv==NOISE_DIV-1: ndiv<=0 and lfsr<={lfsr[15:0], lfsr[16]^lfsr[13]}. Otherwise ndiv<=ndiv+1.
  - If lfsr is ever all-zero, it reloads 17'h00001 on the next step.
- Amplitude a:
  - mode 0: a = crsh.
  - mode 1: a = env (registered).
- Envelope (updates regardless of mode):
  - If pend: env<=crsh, dcnt<=0. Retrigger during decay reloads env.
  - Else if env>0: if dcnt==DECAY_DIV-1 then env<=env-1 and dcnt<=0, else dcnt<=dcnt+1.
  - Else (env==0): hold.
  - env never underflows.
- Sample: x = n ? +(a<<(OUT_W-1-AMP_W)) : -(a<<(OUT_W-1-AMP_W)). Magnitude is at most (2^AMP_W-1)<<(OUT_W-1-AMP_W), so x never overflows OUT_W.
- Filter:
  - y <= y + ((x - y) >>> FILT_SHIFT), using arithmetic shift.
  - The difference is computed in OUT_W+1 bits. y stays in range by construction.
  - FILT_SHIFT=0 gives y<=x.
- out is a register copy of y. It is valid the clk after each enable and holds between enables.
- Mode switch mid-burst: env keeps decaying. Mode 0 simply ignores env.

Test Plan:
- Reset: rst=1 for 3 clks, with enables and trig toggling during reset -> out=0. The first post-reset enable uses lfsr[16]=0, so with NOISE_DIV=1, FILT_SHIFT=0, crsh=15, mode 0, out=-30720.
- Direct mode: NOISE_DIV=1, FILT_SHIFT=0, crsh=15 for 1000 enables -> every out is ±30720 and matches a bit-exact LFSR model. With crsh=0, out=0 throughout.
- Noise rate: NOISE_DIV=4 -> sign of out changes only at enable indices that are multiples of 4, matching the model. clk_en_48KHz held low for 100 clks -> out and lfsr unchanged.
- Envelope: mode 1, DECAY_DIV=4, FILT_SHIFT=0, trig pulse with crsh=8 at enable k -> |out|=16384 for samples k+1..k+4, then 14336, and so on down to 2048. out=0 from sample k+33 onward.
- Retrigger and coincidence:
  - trig asserted in the same clk as an enable, at env=3 -> env reloads to crsh that enable.
  - trig pulse between enables -> consumed at the next enable.
  - rst mid-decay -> env=0, out=0.
- Filter: FILT_SHIFT=3, mode 0, crsh=15 for 2000 enables -> out matches the model filter exactly, |out| <= 30720, and there is no wrap.
